exibe_sequencia: RTL

Sequencing controller for the sequence-display phase of the memory game. At the start of each round the main control unit pulses `iniciar`; this block walks the sequence-memory address from 0 up to the current round limit, lights the LEDs with each stored value for a fixed on-time and blanks them for a fixed off-time, then pulses `pronto` so the main control unit can enter its wait-for-play state. It owns the memory address during display and drives the LED bus; the main control unit owns the memory address during play.

---
 rtl/exibe_sequencia_pkg.sv | 29 ++
 rtl/exibe_sequencia_if.sv | 24 ++
 rtl/exibe_sequencia_contador_tempo.sv | 33 +++
 rtl/exibe_sequencia.sv | 127 ++++++++++++
 4 files changed

// File: rtl/exibe_sequencia_pkg.sv
// Shared types for the sequence-display controller of the memory game.
// State codes double as the debug codes shown on db_estado.
package exibe_sequencia_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    PREPARA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam logic [3:0] DB_INVALIDO = 4'hD;

  localparam int T_ON_PADRAO  = 1000;
  localparam int T_OFF_PADRAO = 500;

  function automatic logic [3:0] codigo_db(estado_t e);
    logic [3:0] c;
    case (e)
      OCIOSO, PREPARA, ACENDE,
      APAGA, PROXIMO, FIM: c = {1'b0, e};
      default:             c = DB_INVALIDO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exibe_sequencia_if.sv
// Control/memory bus between the main control unit and the display block.
// master = control unit + memory side, slave = display block.
interface exibe_sequencia_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              iniciar;
  logic              cancela;
  logic [ADDR_W-1:0] limite;
  logic [DATA_W-1:0] dado;
  logic [ADDR_W-1:0] endereco;
  logic              ocupado;
  logic              pronto;

  modport master (
    output iniciar, cancela, limite, dado,
    input  endereco, ocupado, pronto
  );

  modport slave (
    input  iniciar, cancela, limite, dado,
    output endereco, ocupado, pronto
  );
endinterface

// File: rtl/exibe_sequencia_contador_tempo.sv
// On/off timer shared by the lit and dark phases.
// fim is high while the count equals the selected terminal value.
module contador_tempo #(
  parameter int TIMER_W = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zera,
  input  logic               conta,
  input  logic [TIMER_W-1:0] valor_final,
  output logic               fim
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera)
      cnt_d = '0;
    else if (conta)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign fim = (cnt_q == valor_final);

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence-display controller: walks memory 0..limite, lighting the
// LEDs for T_ON cycles and blanking for T_OFF cycles per item.
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int TIMER_W = 12,
  parameter int T_ON    = T_ON_PADRAO,
  parameter int T_OFF   = T_OFF_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  exibe_sequencia_if.slave  bus,
  output logic [DATA_W-1:0] leds,
  output logic [3:0]        db_estado
);

  localparam logic [TIMER_W-1:0] TON_M1  = TIMER_W'(T_ON - 1);
  localparam logic [TIMER_W-1:0] TOFF_M1 = TIMER_W'(T_OFF - 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic              pronto_q, pronto_d;
  logic              ocupado_q, ocupado_d;

  logic               zera, conta, fim_t;
  logic [TIMER_W-1:0] valor_final;
  logic               valido;

  contador_tempo #(.TIMER_W(TIMER_W)) u_tempo (
    .clock       (clock),
    .reset       (reset),
    .zera        (zera),
    .conta       (conta),
    .valor_final (valor_final),
    .fim         (fim_t)
  );

  always_comb begin
    estado_d    = estado_q;
    end_d       = end_q;
    lim_d       = lim_q;
    zera        = 1'b0;
    conta       = 1'b0;
    valor_final = TON_M1;
    case (estado_q)
      OCIOSO: begin
        zera = 1'b1;
        if (bus.iniciar) begin
          lim_d    = bus.limite;
          end_d    = '0;
          estado_d = PREPARA;
        end
      end
      PREPARA: begin
        zera     = 1'b1;
        estado_d = ACENDE;
      end
      ACENDE: begin
        valor_final = TON_M1;
        if (fim_t) begin
          zera     = 1'b1;
          estado_d = APAGA;
        end else begin
          conta = 1'b1;
        end
      end
      APAGA: begin
        valor_final = TOFF_M1;
        if (fim_t) begin
          zera     = 1'b1;
          estado_d = (end_q == lim_q) ? FIM : PROXIMO;
        end else begin
          conta = 1'b1;
        end
      end
      PROXIMO: begin
        end_d    = end_q + 1'b1;
        estado_d = PREPARA;
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        zera     = 1'b1;
        estado_d = OCIOSO;
      end
    endcase
    // abort wins over everything, including a start in OCIOSO
    if (bus.cancela) begin
      estado_d = OCIOSO;
      end_d    = end_q;
      lim_d    = lim_q;
      zera     = 1'b1;
      conta    = 1'b0;
    end
  end

  assign pronto_d  = (estado_d == FIM);
  assign ocupado_d = (estado_d != OCIOSO);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      end_q     <= '0;
      lim_q     <= '0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      end_q     <= end_d;
      lim_q     <= lim_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign db_estado    = codigo_db(estado_q);
  assign valido       = (db_estado != DB_INVALIDO);
  assign leds         = (estado_q == ACENDE) ? bus.dado : '0;
  assign bus.endereco = end_q;
  assign bus.pronto   = pronto_q & valido;
  assign bus.ocupado  = ocupado_q & valido;

endmodule
